dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the single-cycle data memory: 256-byte, big-endian, byte-addressed, synchronous write, combinational read.
- Requester A is the CPU load/store path. Requester B is a loader/debug/DMA port.
- Serialises word accesses, drives the memory's write-enable/address/data, captures read data, and returns a one-cycle response to the owning requester.
- Rejects misaligned and out-of-range addresses without touching memory.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, word width (fixed at 4 bytes).
- MEM_BYTES, 256, memory size in bytes; last legal word address is MEM_BYTES-4.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  asynchronous, active-high reset.
- i_a_req  in  1  A request; held until o_a_gnt.
- i_a_we  in  1  A write (1) / read (0).
- i_a_addr  in  ADDR_W  A byte address.
- i_a_wdata  in  DATA_W  A write data.
- o_a_gnt  out  1  A request accepted this cycle.
- o_a_rvalid  out  1  A response pulse.
- o_a_rdata  out  DATA_W  A read data, valid with o_a_rvalid.
- o_a_err  out  1  A access rejected, valid with o_a_rvalid.
- i_b_req, i_b_we, i_b_addr, i_b_wdata, o_b_gnt, o_b_rvalid, o_b_rdata, o_b_err: same as A, for requester B.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  memory byte address.
- o_mem_wdata  out  DATA_W  memory write data.
- i_mem_rdata  in  DATA_W  memory combinational read data.

Behaviour:
- Reset values (i_rst high, asynchronous): state IDLE; all gnt/rvalid/err 0; rdata 0; o_mem_we 0; o_mem_addr 0; o_mem_wdata 0; latched request cleared; RR pointer = B.
- FSM states: IDLE, ACCESS, RESP.

IDLE:
- If any req is high, pick a winner and assert its gnt combinationally in this cycle.
- At the clock edge, latch the winner's id, we, addr and wdata, then go to ACCESS.
- No req: stay in IDLE.
- The requester may drop or change req in the cycle after gnt.

ACCESS (exactly one cycle):
- Legal means addr[1:0]==0 and addr<=MEM_BYTES-4.
- Legal write: o_mem_we=1, o_mem_addr/o_mem_wdata = latched values; memory writes at the edge ending this cycle.
- Legal read: o_mem_we=0, o_mem_addr = latched addr; capture i_mem_rdata into the response register at the edge.
- Illegal: o_mem_we held 0 and the err flag is latched.
- Next state is always RESP.

RESP (exactly one cycle):
- Owner's rvalid=1.
- rdata = captured word for a read; 0 for writes and errors.
- err per the ACCESS check.
- Next state IDLE.
- Non-owner outputs stay 0.

Timing and output rules:
- Latency: gnt in cycle N, memory access in N+1, rvalid in N+2. Maximum throughput is 1 access per 3 cycles.
- o_mem_we is high only in ACCESS on a legal write, never for more than one cycle.
- o_mem_addr holds its last value outside ACCESS.
- A request arriving while busy (ACCESS/RESP) waits; gnt is never asserted outside IDLE.

Arbitration:
- Default: fixed priority, A over B.
- Simultaneous A and B requests in IDLE: A granted; B granted at the next IDLE if still requesting.

Reset mid-operation:
- An asynchronous reset during ACCESS drops o_mem_we immediately; the write must not occur.
- The in-flight transaction is discarded and no rvalid is issued.

Optional Feature:
- DM_ARB_RR_EN defined: round-robin arbitration. When both request, grant the requester not granted last. The pointer updates on every grant; reset value B, so A wins the first tie.
- Undefined: fixed A-over-B priority, no pointer register.

Decomposition:
- Shared package dm_arb_pkg:
  - FSM state encoding (IDLE/ACCESS/RESP).
  - Requester id constants (ID_A=0, ID_B=1).
  - WORD_BYTES=4 and the alignment mask.
- One sub-module, dm_arb_pick: combinational winner selection. Inputs: reqs and last-grant pointer. Outputs: one-hot grant and winner id. Both the fixed and RR variants live here under the macro.

Test Plan:
- A write addr 0x10 data 0xDEADBEEF, then A read 0x10: gnt cycle N; o_mem_we=1 only in N+1; read rvalid at N+2 (of the read) with rdata 0xDEADBEEF, err=0.
- B read addr 0x13 (misaligned) and addr 0xFC vs 0x100: 0x13 and 0x100 return err=1, rdata 0, o_mem_we never high; 0xFC returns err=0.
- A and B both request continuously:
  - Without DM_ARB_RR_EN: only A is granted while A holds req.
  - With it: grants alternate A,B,A,B.
- B requests during A's ACCESS cycle: B gnt withheld until IDLE, granted 2 cycles after A's gnt +1; A's rvalid precedes B's gnt.
- i_rst pulsed mid-ACCESS of A write 0x20 data 0x12345678: o_mem_we falls with reset; subsequent read of 0x20 returns the prior contents; no A rvalid.
- Idle with no requests for 10 cycles: all gnt/rvalid/we remain 0, state IDLE.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm_arbiter data-memory front end.
// Build option: DM_ARB_RR_EN selects round-robin tie breaking in dm_arb_pick.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam int         WORD_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'(WORD_BYTES - 1);

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner selection between requester A (bit 0) and B (bit 1).
// DM_ARB_RR_EN defined: ties go to the requester not granted last; otherwise A wins.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt,
  output logic       o_id
);

`ifdef DM_ARB_RR_EN
  always_comb begin
    o_gnt = 2'b00;
    o_id  = ID_A;
    if (i_req[0] && i_req[1]) begin
      if (i_last == ID_B) begin
        o_gnt = 2'b01;
        o_id  = ID_A;
      end else begin
        o_gnt = 2'b10;
        o_id  = ID_B;
      end
    end else if (i_req[0]) begin
      o_gnt = 2'b01;
      o_id  = ID_A;
    end else if (i_req[1]) begin
      o_gnt = 2'b10;
      o_id  = ID_B;
    end
  end
`else
  // Fixed priority ignores the pointer.
  logic w_unused_last;
  assign w_unused_last = i_last;

  always_comb begin
    o_gnt = 2'b00;
    o_id  = ID_A;
    if (i_req[0]) begin
      o_gnt = 2'b01;
      o_id  = ID_A;
    end else if (i_req[1]) begin
      o_gnt = 2'b10;
      o_id  = ID_B;
    end
  end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter and IDLE->ACCESS->RESP sequencer for a 256-byte data memory.
// Build option: DM_ARB_RR_EN enables round-robin tie breaking with a last-grant pointer.
//
// Handshake: a requester holds i_x_req until o_x_gnt is seen high in IDLE; the
// request fields are latched on that edge, the memory is touched in the next cycle,
// and o_x_rvalid pulses for exactly one cycle in the cycle after that.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_gnt,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  output logic              o_a_err,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_gnt,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_b_err,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output state_t            o_dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_id;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [1:0]        w_req;
  logic [1:0]        w_pick_gnt;
  logic              w_pick_id;
  logic              w_last;
  logic              w_grant;
  logic              w_legal;

  assign w_req   = {i_b_req, i_a_req};
  assign w_grant = (r_state == ST_IDLE) && (|w_req);
  assign w_legal = is_aligned(r_addr[1:0]) && (r_addr <= LAST_WORD);

`ifdef DM_ARB_RR_EN
  logic r_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= ID_B;
    end else if (w_grant) begin
      r_last <= w_pick_id;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = ID_B;
`endif

  dm_arb_pick u_pick (
    .i_req  (w_req),
    .i_last (w_last),
    .o_gnt  (w_pick_gnt),
    .o_id   (w_pick_id)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Request fields stay latched after the access so o_mem_addr holds its last value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_id    <= ID_A;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_id <= w_pick_id;
        if (w_pick_id == ID_A) begin
          r_we    <= i_a_we;
          r_addr  <= i_a_addr;
          r_wdata <= i_a_wdata;
        end else begin
          r_we    <= i_b_we;
          r_addr  <= i_b_addr;
          r_wdata <= i_b_wdata;
        end
      end
      if (r_state == ST_ACCESS) begin
        r_err   <= !w_legal;
        r_rdata <= (w_legal && !r_we) ? i_mem_rdata : '0;
      end
    end
  end

  // Write enable is decoded from state so an asynchronous reset kills it at once.
  always_comb begin
    o_a_gnt     = 1'b0;
    o_b_gnt     = 1'b0;
    o_a_rvalid  = 1'b0;
    o_b_rvalid  = 1'b0;
    o_a_rdata   = '0;
    o_b_rdata   = '0;
    o_a_err     = 1'b0;
    o_b_err     = 1'b0;
    o_mem_we    = (r_state == ST_ACCESS) && r_we && w_legal;
    o_mem_addr  = r_addr;
    o_mem_wdata = r_wdata;
    if (w_grant) begin
      o_a_gnt = w_pick_gnt[0];
      o_b_gnt = w_pick_gnt[1];
    end
    if (r_state == ST_RESP) begin
      if (r_id == ID_A) begin
        o_a_rvalid = 1'b1;
        o_a_rdata  = r_rdata;
        o_a_err    = r_err;
      end else begin
        o_b_rvalid = 1'b1;
        o_b_rdata  = r_rdata;
        o_b_err    = r_err;
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a big-endian byte memory model and a response scoreboard.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_BYTES = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  state_t            dbg_state;

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata), .o_a_err(a_err),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata), .o_b_err(b_err),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
  );

  // big-endian byte memory: synchronous write, combinational read
  logic [7:0] mem [256];
  logic       mem_clr;
  logic [7:0] ra;
  assign ra        = mem_addr[7:0];
  assign mem_rdata = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[ra]        <= mem_wdata[31:24];
      mem[ra + 8'd1] <= mem_wdata[23:16];
      mem[ra + 8'd2] <= mem_wdata[15:8];
      mem[ra + 8'd3] <= mem_wdata[7:0];
    end
  end

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [33:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic id, input logic err, input logic [31:0] rdata, input int gcyc);
    exp_q.push_back({id, err, rdata});
    exp_cyc_q.push_back(gcyc);
  endtask

  logic [33:0] mon_got, mon_exp;
  int          mon_cyc;

  always @(negedge clk) begin
    if (!rst && (a_rvalid || b_rvalid)) begin
      check("rvalid_exclusive", {63'd0, a_rvalid & b_rvalid}, 64'd0);
      mon_got = a_rvalid ? {ID_A, a_err, a_rdata} : {ID_B, b_err, b_rdata};
      check("nonowner_quiet", a_rvalid ? {31'd0, b_err, b_rdata} : {31'd0, a_err, a_rdata}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got id/err/rdata 0x%0h with no response pending (cycle %0d)",
                 mon_got, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("resp_id_err_rdata", {30'd0, mon_got}, {30'd0, mon_exp});
        check("resp_latency", 64'(cyc), 64'(mon_cyc + 2));
      end
    end
  end

  // drivers
  task automatic set_req(input logic id, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (id == ID_A) begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end
  endtask

  // Issue one transaction from IDLE; checks memory-side behaviour in ACCESS and RESP.
  task automatic issue(input logic id, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
    int   waited = 0;
    logic got = 1'b0;
    set_req(id, 1'b1, we, addr, wdata);
    while (!got && waited < 20) begin
      @(negedge clk);
      got = (id == ID_A) ? a_gnt : b_gnt;
      waited++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout: id %0d addr 0x%0h got no grant in 20 cycles", id, addr);
      set_req(id, 1'b0, 1'b0, 32'd0, 32'd0);
      return;
    end
    push_exp(id, exp_err, exp_rdata, cyc);
    @(posedge clk); #1;
    set_req(id, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("access_mem_we", {63'd0, mem_we}, {63'd0, we & !exp_err});
    if (!exp_err) check("access_mem_addr", 64'(mem_addr), 64'(addr));
    if (we && !exp_err) check("access_mem_wdata", 64'(mem_wdata), 64'(wdata));
    @(negedge clk);
    check("resp_mem_we_low", {63'd0, mem_we}, 64'd0);
    @(posedge clk); #1;
  endtask

  int   n_gnt;
  logic gid;
  logic exp_gid;
  int   t4_cyc;

  initial begin
    mem_clr = 1'b1;
    set_req(ID_A, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(ID_B, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {57'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, mem_we}, 64'd0);
    check("reset_rdata", {a_rdata, b_rdata}, 64'd0);
    check("reset_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    mem_clr = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // write then read back
    issue(ID_A, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(ID_A, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    // range and alignment boundaries on B
    issue(ID_B, 1'b1, 32'hFC, 32'hCAFEF00D, 1'b0, 32'h0);
    issue(ID_B, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
    issue(ID_B, 1'b0, 32'hFC, 32'h0, 1'b0, 32'hCAFEF00D);
    issue(ID_B, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0);
    issue(ID_B, 1'b1, 32'h100, 32'h55AA55AA, 1'b1, 32'h0);
    issue(ID_B, 1'b1, 32'h12, 32'h0BADBAD0, 1'b1, 32'h0);
    issue(ID_A, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    // both requesting continuously (last grant so far is A, then the pointer-free tie starts)
    issue(ID_B, 1'b0, 32'hFC, 32'h0, 1'b0, 32'hCAFEF00D);
    set_req(ID_A, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(ID_B, 1'b1, 1'b0, 32'hFC, 32'h0);
    n_gnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_gnt || b_gnt) begin
        check("tie_single_gnt", {63'd0, a_gnt & b_gnt}, 64'd0);
        gid = b_gnt;
`ifdef DM_ARB_RR_EN
        exp_gid = n_gnt[0];
`else
        exp_gid = ID_A;
`endif
        check("tie_order", {63'd0, gid}, {63'd0, exp_gid});
        push_exp(gid, 1'b0, gid ? 32'hCAFEF00D : 32'hDEADBEEF, cyc);
        n_gnt++;
      end
    end
    @(posedge clk); #1;
    set_req(ID_A, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(ID_B, 1'b0, 1'b0, 32'd0, 32'd0);
    check("tie_grant_count", 64'(n_gnt), 64'd4);
    repeat (4) @(posedge clk); #1;

    // B arrives while A is busy
    set_req(ID_A, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("busy_a_gnt", {63'd0, a_gnt}, 64'd1);
    if (a_gnt) push_exp(ID_A, 1'b0, 32'hDEADBEEF, cyc);
    t4_cyc = cyc;
    @(posedge clk); #1;
    set_req(ID_A, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(ID_B, 1'b1, 1'b0, 32'h13, 32'h0);
    @(negedge clk);
    check("busy_b_wait_access", {63'd0, b_gnt}, 64'd0);
    @(negedge clk);
    check("busy_b_wait_resp", {63'd0, b_gnt}, 64'd0);
    check("busy_a_rvalid_first", {63'd0, a_rvalid}, 64'd1);
    @(negedge clk);
    check("busy_b_gnt", {63'd0, b_gnt}, 64'd1);
    check("busy_b_gnt_cycle", 64'(cyc), 64'(t4_cyc + 3));
    if (b_gnt) push_exp(ID_B, 1'b1, 32'h0, cyc);
    @(posedge clk); #1;
    set_req(ID_B, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk); #1;

    // reset in the middle of a write access
    issue(ID_A, 1'b1, 32'h20, 32'h11111111, 1'b0, 32'h0);
    set_req(ID_A, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    check("rst_mid_a_gnt", {63'd0, a_gnt}, 64'd1);
    @(posedge clk); #1;
    set_req(ID_A, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("rst_mid_we_before", {63'd0, mem_we}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_we_drops", {63'd0, mem_we}, 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_no_rvalid", {62'd0, a_rvalid, b_rvalid}, 64'd0);
    end
    @(posedge clk); #1;
    issue(ID_A, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11111111);

    // quiet idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", {57'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we, dbg_state},
            {62'd0, ST_IDLE});
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
